// File: rtl/audio_pkg.sv
// Shared constants and types for the audio PWM output path.
package audio_pkg;

  localparam int SAMPLE_W_DEFAULT           = 8;
  localparam int PERIODS_PER_SAMPLE_DEFAULT = 8;
  localparam int FIFO_DEPTH_DEFAULT         = 4;

  // System clock feeding the modulator; sample rate = CLK_FREQ_HZ / 2^SAMPLE_W / PERIODS_PER_SAMPLE.
  localparam int CLK_FREQ_HZ = 100_000_000;

  typedef logic [SAMPLE_W_DEFAULT-1:0] audio_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous sample FIFO; extra pointer bit separates full from empty.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int W     = SAMPLE_W_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head is read combinationally so it can be loaded on the same boundary edge as the pop.
  assign dout = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update; both ends move independently so simultaneous push/pop keeps the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/audio_pwm_modulator.sv
// Sample-paced PWM modulator: FIFO-buffered samples, one per sample interval, compared against a carrier.
module audio_pwm_modulator
  import audio_pkg::*;
#(
  parameter int SAMPLE_W           = SAMPLE_W_DEFAULT,
  parameter int PERIODS_PER_SAMPLE = PERIODS_PER_SAMPLE_DEFAULT,
  parameter int FIFO_DEPTH         = FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PER_W = (PERIODS_PER_SAMPLE > 1) ? $clog2(PERIODS_PER_SAMPLE) : 1;
  localparam logic [SAMPLE_W-1:0] CNT_MAX  = {SAMPLE_W{1'b1}};
  localparam logic [PER_W-1:0]    PER_LAST = PER_W'(PERIODS_PER_SAMPLE - 1);

  logic [SAMPLE_W-1:0] cnt;
  logic [PER_W-1:0]    per;
  logic [SAMPLE_W-1:0] duty;
  logic [SAMPLE_W-1:0] head;
  logic                full;
  logic                empty;
  logic                boundary;
  logic                push;
  logic                pop;

  assign sample_ready = !full;
  assign push         = sample_valid && !full;
  assign boundary     = en && (cnt == CNT_MAX) && (per == PER_LAST);
  assign pop          = boundary && !empty;

  audio_sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (sample_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // Carrier and period counters; disabling parks both at zero so re-enable starts a fresh interval.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      per <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_MAX) begin
        per <= (per == PER_LAST) ? '0 : per + 1'b1;
      end
    end
  end

  // Duty register loads only at a sample boundary; an empty FIFO holds it and flags underrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty     <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= boundary && empty;
      if (pop) begin
        duty <= head;
      end
    end
  end

  // Registered compare gives a clean single-bit output; forced low while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= en && (cnt < duty);
    end
  end

endmodule

// File: doc/audio_pwm_modulator.md
# audio_pwm_modulator

Downstream stage of the audio packaging path. It accepts unsigned PCM samples over a valid/ready handshake and buffers them in a small FIFO. It releases one sample per fixed sample interval and converts it into a registered single-bit PWM stream (`pwm_out`) that drives the board's audio low-pass filter. It owns carrier generation, sample-rate pacing and underrun handling, so the upstream sample source only has to keep the FIFO non-empty.

## Interface
- `SAMPLE_W`, 8: sample width; PWM carrier period = 2^SAMPLE_W clocks.
- `PERIODS_PER_SAMPLE`, 8: carrier periods per sample (100 MHz / 256 / 8 ≈ 48.8 kHz).
- `FIFO_DEPTH`, 4: sample buffer entries, power of two, ≥2.
- `clk` in 1: single system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `en` in 1: run enable; 0 freezes pacing and forces output low.
- `sample_in` in SAMPLE_W: unsigned sample, 0 = silence floor.
- `sample_valid` in 1: `sample_in` is valid this cycle.
- `sample_ready` out 1: FIFO can accept; equals !full.
- `pwm_out` out 1: registered PWM output.
- `underrun` out 1: one-cycle pulse when a sample boundary finds the FIFO empty.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- Push happens when `sample_valid && sample_ready`. `sample_ready` is combinational from the full flag only.
- Carrier counter `cnt` (SAMPLE_W bits) increments every cycle while `en`=1 and wraps MAX→0.
- Period counter `per` counts carrier wraps, 0..PERIODS_PER_SAMPLE-1.
- Sample boundary is the cycle with `cnt`==MAX, `per`==PERIODS_PER_SAMPLE-1 and `en`=1. At that edge:
  - FIFO non-empty: pop the head and load it into `duty`.
  - FIFO empty: hold `duty` unchanged and pulse `underrun`.
- `duty` changes only at a sample boundary, so there are no glitched periods.
- Compare rule: `pwm_out` is registered from (`cnt` < `duty`).
  - `duty`=0 gives constant low.
  - `duty`=MAX gives high for MAX of 2^SAMPLE_W cycles.
- `en`=0: `cnt` and `per` reset to 0, `pwm_out` is 0, and no pop occurs. Pushes are still accepted and `duty` is retained.
- Push and pop in the same cycle on a non-full FIFO: both take effect and `fifo_level` is unchanged.
- Full FIFO with a pop in the same cycle: the push is still refused, because `sample_ready` was 0.
- FIFO pointers wrap modulo FIFO_DEPTH. Use an extra pointer bit to distinguish full from empty.

## Timing
- Reset values: `pwm_out`=0, `underrun`=0, `duty`=0, `cnt`=0, `per`=0, FIFO empty, `fifo_level`=0, `sample_ready`=1.
- Reset asserted mid-operation clears everything on the next edge, including buffered samples. There is no partial period.
- Push at edge t makes `fifo_level` increase, visible from cycle t+1.
- The new `duty` takes effect with `cnt`=0 at the cycle after the boundary edge. `pwm_out` reflects it one cycle later (1-cycle compare register).
- Minimum latency from a push into an empty FIFO to `pwm_out` rising equals the cycles to the next sample boundary + 2.
- `underrun` is high for exactly the one cycle following the boundary edge.
- First boundary after reset with `en`=1 continuously falls at cycle PERIODS_PER_SAMPLE·2^SAMPLE_W − 1.

## Structure
- Shared package `audio_pkg`:
  - Constants SAMPLE_W_DEFAULT=8, PERIODS_PER_SAMPLE_DEFAULT=8, FIFO_DEPTH_DEFAULT=4.
  - Typedef `audio_sample_t` (logic [SAMPLE_W-1:0]).
  - Localparam for clock frequency 100 MHz.
- Sub-module `audio_sample_fifo`: synchronous FIFO with push/pop, full, empty and level outputs.
- The top level contains the carrier counter, period counter, boundary detect, duty register and compare register.

## Test plan
All scenarios use SAMPLE_W=4, PERIODS_PER_SAMPLE=2, FIFO_DEPTH=4 (boundary every 32 cycles).
- Reset check: hold `reset` for 2 cycles.
  - Required: `pwm_out`=0, `sample_ready`=1, `fifo_level`=0, `underrun`=0.
  - With no samples pushed: the first `underrun` pulse occurs at cycle 32 after reset release, and `pwm_out` stays 0.
- Duty accuracy: push 4, let it load.
  - Required: each 16-cycle period shows `pwm_out` high for exactly 4 cycles.
  - Push 0: constant low. Push 15: high 15 of 16 cycles.
- Fill and full:
  - Push 5 samples back-to-back into an empty FIFO. The first 4 are accepted and `sample_ready`=0 after the 4th; the 5th is refused.
  - At the next boundary `fifo_level` goes 4→3 and `sample_ready` returns to 1.
- Order and underrun:
  - Push 3, 7, 11. `duty` sequence on successive boundaries is 3, 7, 11.
  - The 4th boundary pulses `underrun` once and holds duty 11.
- Simultaneous push/pop: `fifo_level`=2 with a push on the boundary cycle gives `fifo_level` still 2 and the popped value is the older head.
- Mid-operation control:
  - Deassert `en` mid-period: `pwm_out` is 0 the next cycle and `cnt` is 0. Re-enable: the boundary occurs 32 cycles later.
  - Assert `reset` with `fifo_level`=3: `fifo_level` is 0 and `duty` is 0.
